// File: rtl/bit_scan8_pkg.sv
// bit_scan_pkg: definitions shared by the bit_scan8 design and its bench.
//   WIDTH      : request word width (8)
//   IDXW       : index width, clog2(WIDTH)
//   state_e    : scanner states, IDLE = 0, SCAN = 1
//   lowest_set : reference lowest-set-bit function (returns 0 for an empty word)
package bit_scan_pkg;

  localparam int WIDTH = 8;
  localparam int IDXW  = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic logic [IDXW-1:0] lowest_set(input logic [WIDTH-1:0] word);
    logic [IDXW-1:0] idx;
    idx = '0;
    // Walk downwards so the lowest set bit is the one left standing.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (word[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bit_scan8_if.sv
// bit_scan8_if: request-in / index-out handshake bundle for bit_scan8.
//   in, in_valid, in_ready      : request word handshake (producer -> scanner)
//   out, out_valid, out_ready   : index handshake (scanner -> consumer)
//   out_last                    : current index is the final pending bit
//   any                         : OR of all still-pending bits
//   zero                        : one-cycle pulse when an all-zero word is accepted
// Modports: master = producer/consumer side, slave = scanner side.
interface bit_scan8_if;
  import bit_scan_pkg::*;

  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [IDXW-1:0]  out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             any;
  logic             zero;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last, any, zero
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last, any, zero
  );

endinterface

// File: rtl/bit_scan8_pri_enc8.sv
// pri_enc8: combinational lowest-set-bit encoder for an 8-bit word.
//   in    [WIDTH-1:0] : word to encode
//   out   [IDXW-1:0]  : index of the lowest set bit, 0 when in == 0
//   found             : |in
// Built as a pair / quad / octet tree, the same shape as an 8-way OR
// reduction, with an index bit contributed at each level.
module pri_enc8
  import bit_scan_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [IDXW-1:0]  out,
  output logic             found
);

  logic [3:0]      pair_found;
  logic [3:0]      pair_idx;
  logic [1:0]      quad_found;
  logic [1:0][1:0] quad_idx;
  logic [2:0]      raw_idx;

  // Each level prefers its lower half when that half holds any bit,
  // which is what makes the result the lowest set bit overall.
  always_comb begin
    pair_found = '0;
    pair_idx   = '0;
    quad_found = '0;
    quad_idx   = '0;
    for (int p = 0; p < 4; p++) begin
      pair_found[p] = in[2*p] | in[2*p+1];
      pair_idx[p]   = ~in[2*p];
    end
    for (int q = 0; q < 2; q++) begin
      quad_found[q] = pair_found[2*q] | pair_found[2*q+1];
      quad_idx[q]   = pair_found[2*q] ? {1'b0, pair_idx[2*q]}
                                      : {1'b1, pair_idx[2*q+1]};
    end
    found   = quad_found[0] | quad_found[1];
    raw_idx = quad_found[0] ? {1'b0, quad_idx[0]} : {1'b1, quad_idx[1]};
    // An empty word reports index 0 rather than whatever the tree falls to.
    out     = found ? raw_idx : '0;
  end

endmodule

// File: rtl/bit_scan8.sv
// bit_scan8: sequential bit scanner. Accepts an 8-bit request word and emits
// the index of each set bit, lowest first, one per output handshake.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : bit_scan8_if slave modport (request in, index out, any, zero)
module bit_scan8
  import bit_scan_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  bit_scan8_if.slave   bus
);

  localparam logic [0:0]       S_IDLE   = IDLE;
  localparam logic [0:0]       S_SCAN   = SCAN;
  localparam logic [WIDTH-1:0] PEND_ONE = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             zero_q, zero_d;

  logic [IDXW-1:0]  enc_idx;
  logic             enc_found;
  logic             is_last;

  pri_enc8 u_enc (
    .in    (pend_q),
    .out   (enc_idx),
    .found (enc_found)
  );

  // Clearing the lowest set bit leaves nothing exactly when one bit remains.
  assign is_last = ((pend_q & (pend_q - PEND_ONE)) == '0);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_SCAN);
  assign bus.out       = enc_idx;
  assign bus.out_last  = is_last;
  assign bus.any       = enc_found;
  assign bus.zero      = zero_q;

  // Next-state logic: load a nonzero word and scan it out; an empty word
  // only raises the one-cycle zero pulse. Taking an index drops the lowest
  // pending bit, which is always the one being presented.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in != '0) begin
            pend_d  = bus.in;
            state_d = S_SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (bus.out_ready) begin
          pend_d = pend_q & (pend_q - PEND_ONE);
          if (is_last) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State registers; reset drops any word still being scanned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_bit_scan8.sv
// tb_bit_scan8: scoreboard bench for bit_scan8. Stimulus pushes the
// hand-computed index sequence of each accepted word; a monitor pops and
// compares on every output handshake and also checks the zero pulse and
// output stability under backpressure.
module tb_bit_scan8;
  import bit_scan_pkg::*;

  typedef struct {
    int idx;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int passes = 0;
  int zero_set = 0;
  exp_t exp_q[$];

  bit_scan8_if bus ();

  bit_scan8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Present a word, wait (bounded) for acceptance, then queue the expected
  // indices. exp_list holds one hex digit per output, first output in the
  // lowest digit. Called and returns 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic [7:0] word, input logic [31:0] exp_list,
                                input int n);
    int cnt;
    exp_t e;
    bus.in = word;
    bus.in_valid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.in_ready && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check_output("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        e.idx  = int'(exp_list[4*i +: 4]);
        e.last = (i == n - 1) ? 1 : 0;
        exp_q.push_back(e);
      end
      if (word == 8'h00) zero_set++;
    end
  endtask

  task automatic wait_drain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      cnt++;
      @(posedge clk);
    end
    #1;
    check_output(name, exp_q.size(), 0);
  endtask

  // Monitor: compare every handshake against the scoreboard, the zero pulse
  // against the stimulus record, and held data during stalls.
  initial begin : monitor
    int last_set;
    logic stalled;
    int prev_out;
    int prev_last;
    logic zexp;
    exp_t e;
    last_set = 0;
    stalled = 1'b0;
    prev_out = 0;
    prev_last = 0;
    forever begin
      @(negedge clk);
      zexp = (zero_set != last_set);
      last_set = zero_set;
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (bus.zero || zexp) check_output("zero_pulse", int'(bus.zero), int'(zexp));
        if (stalled) begin
          check_output("hold_valid", int'(bus.out_valid), 1);
          check_output("hold_out", int'(bus.out), prev_out);
          check_output("hold_last", int'(bus.out_last), prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_out: got index %0d, expected no output", bus.out);
          end else begin
            e = exp_q.pop_front();
            check_output("out_idx", int'(bus.out), e.idx);
            check_output("out_last", int'(bus.out_last), e.last);
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        prev_out = int'(bus.out);
        prev_last = int'(bus.out_last);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int ph;
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", int'(bus.in_ready), 1);
    check_output("rst_out_valid", int'(bus.out_valid), 0);
    check_output("rst_out", int'(bus.out), 0);
    check_output("rst_out_last", int'(bus.out_last), 1);
    check_output("rst_any", int'(bus.any), 0);
    check_output("rst_zero", int'(bus.zero), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic scan");
    apply_stimulus(8'hA4, 32'h752, 3);
    check_output("basic_valid", int'(bus.out_valid), 1);
    check_output("basic_any", int'(bus.any), 1);
    check_output("basic_busy", int'(bus.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("basic_any_done", int'(bus.any), 0);
    check_output("basic_in_ready", int'(bus.in_ready), 1);
    check_output("basic_valid_done", int'(bus.out_valid), 0);
    wait_drain("basic_drain");

    $display("[TB] backpressure");
    apply_stimulus(8'hFF, 32'h76543210, 8);
    ph = 0;
    while (exp_q.size() != 0 && ph < 200) begin
      bus.out_ready = (ph % 3 == 0);
      @(posedge clk);
      #1;
      ph++;
    end
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    @(posedge clk);
    #1;
    check_output("bp_valid_done", int'(bus.out_valid), 0);
    check_output("bp_any_done", int'(bus.any), 0);

    $display("[TB] zero words");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(8'h00, 32'h0, 0);
      check_output("zero_in_ready", int'(bus.in_ready), 1);
      check_output("zero_out_valid", int'(bus.out_valid), 0);
      check_output("zero_flag", int'(bus.zero), 1);
    end
    @(posedge clk);
    #1;
    check_output("zero_flag_clear", int'(bus.zero), 0);

    $display("[TB] single and edge bits");
    apply_stimulus(8'h01, 32'h0, 1);
    wait_drain("bit0_drain");
    apply_stimulus(8'h80, 32'h7, 1);
    wait_drain("bit7_drain");
    @(posedge clk);
    #1;

    $display("[TB] ignored input during scan");
    apply_stimulus(8'h03, 32'h10, 2);
    apply_stimulus(8'h10, 32'h4, 1);
    wait_drain("ign_drain");
    @(posedge clk);
    #1;
    check_output("ign_valid_done", int'(bus.out_valid), 0);

    $display("[TB] reset mid-scan");
    apply_stimulus(8'hF0, 32'h7654, 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_output("mid_rst_valid", int'(bus.out_valid), 0);
    check_output("mid_rst_any", int'(bus.any), 0);
    check_output("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    check_output("mid_rst_valid_next", int'(bus.out_valid), 0);
    check_output("mid_rst_any_next", int'(bus.any), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(8'h02, 32'h1, 1);
    wait_drain("post_rst_drain");
    @(posedge clk);
    #1;
    check_output("post_rst_valid", int'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bit_scan8.md
# bit_scan8

Sequential bit scanner: the expanding counterpart of the 8-way OR reduction. It accepts an 8-bit request word and emits the index of every set bit, lowest first, one per output handshake. It also reports whether any bits are still pending, which is the OR of the remaining word. It sits between a register or memory-mapped request word and any consumer that services requests one at a time.

## Interface
- WIDTH, 8, word width; power of two, minimum 2.
- IDXW, log2(WIDTH) = 3, index width; derived, not overridden.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  request word.
- in_valid  input  1  `in` is valid.
- in_ready  output  1  block can accept a word.
- out  output  IDXW  index of the current lowest pending bit.
- out_valid  output  1  `out` is valid.
- out_ready  input  1  consumer takes `out`.
- out_last  output  1  `out` is the final pending bit of this word.
- any  output  1  OR of all pending bits.
- zero  output  1  one-cycle pulse: an all-zero word was accepted.

## Operation
- State machine has two states, IDLE and SCAN. Registers: state, pend[WIDTH-1:0], zero.
- **IDLE**
  - in_ready = 1; out_valid = 0.
  - An accept is in_valid && in_ready.
  - On accept with in != 0: pend <= in; go to SCAN.
  - On accept with in == 0: pend stays 0; zero <= 1 for exactly one cycle; stay in IDLE.
- **SCAN**
  - in_ready = 0; out_valid = 1.
  - out = index of the lowest set bit of pend, from a combinational priority encoder.
  - out_last = (pend & (pend - 1)) == 0.
  - When out_valid && out_ready: clear bit `out` of pend. If out_last, go to IDLE; otherwise stay in SCAN.
  - When out_ready = 0: pend, out and out_last hold stable. Output is AXI-style: valid does not drop and data does not change until taken.
- any = |pend in every state. It equals 0 in IDLE after a completed scan.
- in_valid in SCAN is ignored. No word is accepted and none is lost; the producer holds `in` until in_ready.
- **Reset**, async-assert, sampled release:
  - state = IDLE, pend = 0, zero = 0.
  - Outputs: in_ready = 1, out_valid = 0, out = 0, out_last = 1 (pend = 0), any = 0.
  - Reset in the middle of a scan discards the remaining pending bits immediately, with no further outputs.

## Timing
- Accept in cycle N puts out_valid = 1 with the first index in cycle N+1 (registered, latency 1).
- With out_ready held at 1, a word with k set bits yields k outputs in cycles N+1 .. N+k.
- in_ready returns to 1 in cycle N+k+1, so the next accept is no earlier than N+k+1.
- Peak throughput is 1 index per cycle, plus 1 idle cycle between words.
- A zero word accepted in cycle N gives zero = 1 in cycle N+1 only. in_ready stays 1, so back-to-back zero words are accepted every cycle.
- The last handshake and the return to IDLE occur on the same edge. There is no overlap between accepting a new word and emitting the last index.

## Structure
- Shared package `bit_scan_pkg` holds:
  - the state enum (IDLE = 0, SCAN = 1);
  - the WIDTH default and IDXW derivation (clog2);
  - a lowest-set-bit helper function, for use by the bench model.
- One natural sub-module, `pri_enc8`: a combinational lowest-set-bit encoder.
  - Ports: `in` [WIDTH-1:0], `out` [IDXW-1:0], `found`.
  - Tree-structured, mirroring the 8-way OR reduction.
  - `found` = |in, and this drives `any`.

## Test plan
- **Basic scan.** Reset, then in = 8'b1010_0100 with out_ready = 1.
  - out = 2, 5, 7 on consecutive cycles; out_last = 1 only with 7.
  - any falls to 0 after the last handshake; in_ready = 1 on the following cycle.
- **Backpressure.** in = 8'hFF with out_ready toggled 1,0,0,1,...
  - out holds stable while stalled; all of 0..7 are emitted exactly once, in order.
- **Zero word.** Accept in = 8'h00 three times back to back.
  - zero pulses for one cycle per accept; out_valid stays 0; in_ready stays 1.
- **Single and edge bits.**
  - in = 8'h01 gives one output, out = 0 with out_last = 1.
  - in = 8'h80 gives out = 7 with out_last = 1.
- **Ignored input during SCAN.** Accept 8'h03, then hold in_valid = 1 with in = 8'h10 during the scan.
  - Outputs are 0 then 1. 8'h10 is accepted only when in_ready returns, then yields out = 4.
- **Reset mid-scan.** Accept 8'hF0 and take one output (4), then assert reset.
  - Next cycle: out_valid = 0, any = 0, in_ready = 1. After release, 8'h02 yields out = 1 only.
